// File: rtl/uart_rx_byte_if.sv
// Purpose: serial input plus byte-level valid/ready output bundle of the UART receiver.
// Latency: none, wiring only.
// Backpressure: ready from the consumer side holds data/valid on the receiver side.
interface uart_rx_byte_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  // Receiver side: samples the line, presents bytes.
  modport master (
    input  rx,
    input  ready,
    output data,
    output valid,
    output frame_err,
    output overrun
  );

  // Line driver / byte consumer side.
  modport slave (
    output rx,
    output ready,
    input  data,
    input  valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_byte.sv
// Purpose: 8N1 UART receiver, 3-sample majority per bit, byte held in a valid/ready register.
// Latency: valid rises 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 4 cycles after the first low rx sample.
// Backpressure: byte held until ready; a byte completing while the register is full is dropped (overrun pulse).
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           CP,
  input  logic           RST,
  uart_rx_byte_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] C_SMP0 = CW'(H - 1);
  localparam logic [CW-1:0] C_SMP1 = CW'(H);
  localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_t;

  logic          rx_meta_q;
  logic          rx_s_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [1:0]    smp_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          overrun_q;

  logic          bit_d;
  logic          decide_d;
  logic [CW-1:0] cnt_inc_d;

  // Bit value is the majority of the two stored mid-bit samples and the current one.
  always_comb begin
    bit_d     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);
    decide_d  = (cnt_q == C_DEC);
    cnt_inc_d = cnt_q + CW'(1);
  end

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge CP) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame FSM together with the output holding register and status pulses.
  always_ff @(posedge CP) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      smp_q       <= 2'b11;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (valid_q && bus.ready) valid_q <= 1'b0;

      if (cnt_q == C_SMP0) smp_q[0] <= rx_s_q;
      if (cnt_q == C_SMP1) smp_q[1] <= rx_s_q;

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) state_q <= S_START;
        end
        S_START: begin
          cnt_q <= cnt_inc_d;
          if (decide_d && bit_d) begin
            // Start bit did not hold low through mid-bit: treat as a glitch.
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == C_LAST) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        S_DATA: begin
          cnt_q <= cnt_inc_d;
          if (decide_d) shift_q <= {bit_d, shift_q[7:1]};
          if (cnt_q == C_LAST) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end
        end
        S_STOP: begin
          cnt_q <= cnt_inc_d;
          if (decide_d) begin
            cnt_q <= '0;
            if (bit_d) begin
              // Leave half a bit early so the next start edge is not missed.
              state_q <= S_IDLE;
              if (!valid_q || bus.ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HI;
            end
          end
        end
        S_WAIT_HI: begin
          cnt_q <= '0;
          // A held-low break must not be mistaken for a new start bit.
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Purpose: self-checking bench for uart_rx_byte with a queue-based byte reference model.
// Latency: checks the first-frame valid latency in cycles.
// Backpressure: exercises ready low (overrun) and ready high delivery.
module tb_uart_rx_byte;
  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  localparam int LAT = 9 * CPB + H + 1 + 3;

  logic CP  = 1'b0;
  logic RST = 1'b1;

  uart_rx_byte_if bus ();

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .CP  (CP),
    .RST (RST),
    .bus (bus)
  );

  always #5 CP = ~CP;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bytes expected at the consumer, plus event counters.
  logic [7:0] exp_q[$];
  int cyc       = 0;
  int hs_cnt    = 0;
  int fe_cnt    = 0;
  int ov_cnt    = 0;
  int vhi_cnt   = 0;
  int rise_cyc  = 0;
  int start_cyc = 0;
  logic valid_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  always @(posedge CP) cyc <= cyc + 1;

  // Consumer-side monitor: every handshake must match the head of the expected queue.
  always @(negedge CP) begin
    if (!RST) begin
      logic [7:0] e;
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun)   ov_cnt++;
      if (bus.valid)     vhi_cnt++;
      if (bus.frame_err || bus.overrun)
        check_eq("fe_ov_excl", 32'(bus.frame_err & bus.overrun), 32'd0);
      if (bus.valid && !valid_prev) rise_cyc = cyc;
      if (bus.valid && bus.ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", 32'(bus.valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rx_data", 32'(bus.data), 32'(e));
        end
      end
    end
    valid_prev = bus.valid;
  end

  task automatic drive_bit(input logic v);
    bus.rx = v;
    repeat (CPB) @(posedge CP);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge CP);
    #1;
    start_cyc = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CP);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"},  32'(bus.data), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check_eq({tag, "_fe"},    32'(bus.frame_err), 32'd0);
    check_eq({tag, "_ov"},    32'(bus.overrun), 32'd0);
  endtask

  initial begin
    int hs0, fe0, ov0, vh0, exp_fe;
    logic [7:0] b;
    logic [7:0] tx_in [3];
    tx_in[0] = 8'd42; tx_in[1] = 8'd23; tx_in[2] = 8'd13;

    bus.rx    = 1'b1;
    bus.ready = 1'b0;
    RST       = 1'b1;
    repeat (4) @(negedge CP);
    check_all_zero("reset");
    @(posedge CP); #1;
    RST = 1'b0;
    idle(4);

    // Single byte with ready high: one-cycle valid pulse, fixed latency.
    bus.ready = 1'b1;
    hs0 = hs_cnt; fe0 = fe_cnt; ov0 = ov_cnt; vh0 = vhi_cnt;
    exp_q.push_back(8'h2A);
    send_frame(8'h2A, 1'b1);
    idle(4);
    check_eq("t1_handshakes", 32'(hs_cnt - hs0), 32'd1);
    check_eq("t1_latency",    32'(rise_cyc - start_cyc), 32'(LAT));
    check_eq("t1_valid_width", 32'(vhi_cnt - vh0), 32'd1);
    check_eq("t1_fe",         32'(fe_cnt - fe0), 32'd0);
    check_eq("t1_ov",         32'(ov_cnt - ov0), 32'd0);

    // Back-to-back bytes with ready low: first kept, second dropped with overrun.
    bus.ready = 1'b0;
    hs0 = hs_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h17);
    send_frame(8'h17, 1'b1);
    send_frame(8'h0D, 1'b1);
    idle(4);
    check_eq("t2_valid_held", 32'(bus.valid), 32'd1);
    check_eq("t2_data_held",  32'(bus.data), 32'h17);
    check_eq("t2_overrun",    32'(ov_cnt - ov0), 32'd1);
    check_eq("t2_no_hs",      32'(hs_cnt - hs0), 32'd0);
    bus.ready = 1'b1;
    repeat (2) @(negedge CP);
    check_eq("t2_valid_clr",  32'(bus.valid), 32'd0);
    check_eq("t2_hs",         32'(hs_cnt - hs0), 32'd1);

    // Stop bit low followed by a break: one frame error, no byte, no restart.
    hs0 = hs_cnt; fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    idle(40);
    check_eq("t3_fe",        32'(fe_cnt - fe0), 32'd1);
    check_eq("t3_no_valid",  32'(bus.valid), 32'd0);
    check_eq("t3_no_hs",     32'(hs_cnt - hs0), 32'd0);
    bus.rx = 1'b1;
    idle(10);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(4);
    check_eq("t3_after_hs",  32'(hs_cnt - hs0), 32'd1);
    check_eq("t3_fe_once",   32'(fe_cnt - fe0), 32'd1);

    // Short low glitch on the idle line.
    hs0 = hs_cnt; fe0 = fe_cnt; vh0 = vhi_cnt;
    bus.rx = 1'b0;
    idle(5);
    bus.rx = 1'b1;
    idle(3 * CPB);
    check_eq("t4_no_valid", 32'(vhi_cnt - vh0), 32'd0);
    check_eq("t4_no_fe",    32'(fe_cnt - fe0), 32'd0);
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    send_frame(b, 1'b1);
    idle(4);
    check_eq("t4_recover",  32'(hs_cnt - hs0), 32'd1);

    // Reset during bit 4 of 0xFF discards the partial frame.
    bus.rx = 1'b0;
    idle(CPB);
    bus.rx = 1'b1;
    idle(4 * CPB + H);
    RST = 1'b1;
    repeat (3) @(negedge CP);
    check_all_zero("midreset");
    @(posedge CP); #1;
    RST = 1'b0;
    idle(4 * CPB);
    hs0 = hs_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(4);
    check_eq("t5_only_3c", 32'(hs_cnt - hs0), 32'd1);

    // Line driven by the reverse stage, which bit-reverses each TX byte.
    hs0 = hs_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(rev8(tx_in[i]));
      send_frame(rev8(tx_in[i]), 1'b1);
    end
    idle(4);
    check_eq("t6_rev_count", 32'(hs_cnt - hs0), 32'd3);

    // Random frames, gaps and occasional bad stop bits.
    hs0 = hs_cnt; fe0 = fe_cnt; ov0 = ov_cnt; exp_fe = 0;
    for (int i = 0; i < 12; i++) begin
      int gap;
      b   = 8'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 12));
      if ($urandom_range(0, 4) == 0) begin
        send_frame(b, 1'b0);
        idle(int'($urandom_range(0, 30)));
        bus.rx = 1'b1;
        idle(4);
        exp_fe++;
      end else begin
        exp_q.push_back(b);
        send_frame(b, 1'b1);
      end
      idle(gap);
    end
    idle(4);
    check_eq("t7_fe_count", 32'(fe_cnt - fe0), 32'(exp_fe));
    check_eq("t7_ov_count", 32'(ov_cnt - ov0), 32'd0);
    check_eq("t7_hs_count", 32'(hs_cnt - hs0), 32'(12 - exp_fe));
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
